sdspi_saver: RTL

SDSPI_SAVER -- requirements
Module: sdspi_saver

---
 rtl/sdspi_saver_if.sv | 22 ++
 rtl/sdspi_saver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdspi_saver_if.sv
// sdspi_saver_if: APB-style bus between the saver and the SD controller.
// Master side drives the access, slave side completes it.
interface sdspi_saver_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/sdspi_saver.sv
// sdspi_saver: copies RAM words into SD sectors through the controller.
// Define SDSPI_SAVER_CHKSUM_EN for a byte checksum in w_saver_status.
module sdspi_saver #(
  parameter logic [15:0] DEVADDR   = 16'h0000,
  parameter logic [15:0] BLOCKADDR = 16'h0200,
  parameter int          BLOCKSIZE = 512
) (
  input  logic        clk27mhz,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] start_sector,
  input  logic [31:0] nwords,
  output logic [31:0] RADDR,
  output logic        RE,
  input  logic [31:0] RDATA,
  input  logic        RVALID,
  sdspi_saver_if.master apb,
  input  logic        sdsbusy,
  input  logic [31:0] sdspi_status,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] w_saver_status
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    MRD     = 4'd1,
    MWAIT   = 4'd2,
    BWR     = 4'd3,
    BWAIT   = 4'd4,
    CMD     = 4'd5,
    CMDWAIT = 4'd6,
    SDSTART = 4'd7,
    SDEND   = 4'd8
  } state_t;

  localparam logic [31:0] MASK = 32'(BLOCKSIZE - 1);

  state_t      st_q, st_d;
  logic [31:0] sector_q, sector_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] bidx_q, bidx_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] raddr_q, raddr_d;
  logic        re_q, re_d;
  logic        psel_q, psel_d;
  logic        pen_q, pen_d;
  logic        pwr_q, pwr_d;
  logic [15:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [15:0] chk;
`ifdef SDSPI_SAVER_CHKSUM_EN
  logic [15:0] chk_q, chk_d;
`endif

  logic [7:0]  sdctrl;
  logic [7:0]  sdst;
  logic [31:0] nb;
  logic        pad;
  logic        wdone;
  logic [31:0] rem_n;
  logic [7:0]  bsel;
  logic        unused_in;

  assign sdctrl = sdspi_status[15:8];
  assign sdst   = sdspi_status[7:0];
  assign nb     = bidx_q + 32'd1;
  assign pad    = (rem_q == 32'd0);
  assign wdone  = !pad && (bidx_q[1:0] == 2'd3);
  assign rem_n  = wdone ? rem_q - 32'd1 : rem_q;
  assign bsel   = pad ? 8'h00
                : wbuf_q[{bidx_q[1:0], 3'b000} +: 8];
  assign unused_in = ^{apb.prdata, sdspi_status[31:16]};

  // Next-state and next-register logic for the copy sequencer
  always_comb begin
    st_d     = st_q;
    sector_d = sector_q;
    rem_d    = rem_q;
    waddr_d  = waddr_q;
    bidx_d   = bidx_q;
    wbuf_d   = wbuf_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    raddr_d  = raddr_q;
    re_d     = re_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwr_d    = pwr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
`ifdef SDSPI_SAVER_CHKSUM_EN
    chk_d    = chk_q;
`endif
    unique case (st_q)
      IDLE: if (start) begin
        sector_d = start_sector;
        rem_d    = nwords;
        waddr_d  = 32'd0;
        bidx_d   = 32'd0;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef SDSPI_SAVER_CHKSUM_EN
        chk_d    = 16'd0;
`endif
        if (nwords == 32'd0) begin
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          st_d   = MRD;
        end
      end
      MRD: begin
        raddr_d = waddr_q;
        re_d    = 1'b1;
        st_d    = MWAIT;
      end
      MWAIT: if (RVALID) begin
        wbuf_d = RDATA;
        re_d   = 1'b0;
        st_d   = BWR;
      end
      BWR: if (!apb.pready && sdctrl == 8'd0) begin
        psel_d   = 1'b1;
        pen_d    = 1'b1;
        pwr_d    = 1'b1;
        paddr_d  = BLOCKADDR + (bidx_q[15:0] & MASK[15:0]);
        pwdata_d = {24'h0, bsel};
`ifdef SDSPI_SAVER_CHKSUM_EN
        chk_d    = chk_q + {8'h0, bsel};
`endif
        st_d     = BWAIT;
      end
      BWAIT: if (apb.pready) begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
        pwr_d  = 1'b0;
        if (apb.pslverr) begin
          err_d    = 1'b1;
          busy_d   = 1'b0;
          paddr_d  = 16'h0;
          pwdata_d = 32'h0;
          st_d     = IDLE;
        end else begin
          bidx_d = nb;
          if (wdone) begin
            waddr_d = waddr_q + 32'd4;
            rem_d   = rem_n;
          end
          if ((nb & MASK) == 32'd0)
            st_d = CMD;
          else if (wdone && rem_n != 32'd0)
            st_d = MRD;
          else
            st_d = BWR;
        end
      end
      CMD: if (!apb.pready && sdctrl == 8'd0) begin
        psel_d   = 1'b1;
        pen_d    = 1'b1;
        pwr_d    = 1'b1;
        paddr_d  = DEVADDR;
        pwdata_d = {1'b1, sector_q[30:0]};
        st_d     = CMDWAIT;
      end
      CMDWAIT: if (apb.pready) begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
        pwr_d  = 1'b0;
        if (apb.pslverr) begin
          err_d    = 1'b1;
          busy_d   = 1'b0;
          paddr_d  = 16'h0;
          pwdata_d = 32'h0;
          st_d     = IDLE;
        end else begin
          st_d = SDSTART;
        end
      end
      SDSTART: if (sdsbusy && sdst != 8'd0) begin
        st_d = SDEND;
      end
      SDEND: if (!sdsbusy && sdst == 8'd0 && sdctrl == 8'd0) begin
        sector_d = sector_q + 32'd1;
        bidx_d   = 32'd0;
        if (rem_q != 32'd0) begin
          st_d = MRD;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
          st_d   = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk27mhz or negedge resetn) begin
    if (!resetn) begin
      st_q     <= IDLE;
      sector_q <= 32'd0;
      rem_q    <= 32'd0;
      waddr_q  <= 32'd0;
      bidx_q   <= 32'd0;
      wbuf_q   <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      raddr_q  <= 32'd0;
      re_q     <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= 16'd0;
      pwdata_q <= 32'd0;
`ifdef SDSPI_SAVER_CHKSUM_EN
      chk_q    <= 16'd0;
`endif
    end else begin
      st_q     <= st_d;
      sector_q <= sector_d;
      rem_q    <= rem_d;
      waddr_q  <= waddr_d;
      bidx_q   <= bidx_d;
      wbuf_q   <= wbuf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      raddr_q  <= raddr_d;
      re_q     <= re_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
`ifdef SDSPI_SAVER_CHKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

`ifdef SDSPI_SAVER_CHKSUM_EN
  assign chk = chk_q;
`else
  assign chk = 16'h0;
`endif

  assign RADDR          = raddr_q;
  assign RE             = re_q;
  assign apb.psel       = psel_q;
  assign apb.penable    = pen_q;
  assign apb.pwrite     = pwr_q;
  assign apb.paddr      = paddr_q;
  assign apb.pwdata     = pwdata_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ERR            = err_q;
  assign w_saver_status = {chk, 8'h0, 4'h0, st_q};

endmodule
